// File: rtl/dmem_pkg.sv
`default_nettype none
// +----------------------------------------------------------------+
// | Module   : dmem_pkg                                            |
// | Brief    : Access-width encodings, FSM states and base address |
// | Revision : 1.0                                                 |
// +----------------------------------------------------------------+
package dmem_pkg;

  localparam logic [1:0] W_BYTE = 2'b00;
  localparam logic [1:0] W_HALF = 2'b01;
  localparam logic [1:0] W_WORD = 2'b10;
  localparam logic [1:0] W_RSVD = 2'b11;

  localparam logic [31:0] c_base_addr_default = 32'h1001_0000;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    WAIT = 2'd1,
    RESP = 2'd2
  } state_t;

endpackage
`default_nettype wire

// File: rtl/dmem_if.sv
`default_nettype none
// +----------------------------------------------------------------+
// | Module   : dmem_if                                             |
// | Brief    : Request/response bus between a core and dmem        |
// | Revision : 1.0                                                 |
// +----------------------------------------------------------------+
interface dmem_if;

  logic        req;
  logic        we;
  logic [31:0] addr;
  logic [1:0]  width;
  logic        ext;
  logic [31:0] wdata;
  logic        ready;
  logic        valid;
  logic [31:0] rdata;
  logic        err;

  modport master (
    output req, we, addr, width, ext, wdata,
    input  ready, valid, rdata, err
  );

  modport slave (
    input  req, we, addr, width, ext, wdata,
    output ready, valid, rdata, err
  );

endinterface
`default_nettype wire

// File: rtl/dmem_array.sv
`default_nettype none
// +----------------------------------------------------------------+
// | Module   : dmem_array                                          |
// | Brief    : Word array with per-byte write enables, async read  |
// | Revision : 1.0                                                 |
// +----------------------------------------------------------------+
module dmem_array #(
  parameter  int DEPTH_WORDS = 1024,
  localparam int c_aw        = $clog2(DEPTH_WORDS)
) (
  input  wire             clk,
  input  wire [3:0]       i_be,
  input  wire [c_aw-1:0]  i_idx,
  input  wire [31:0]      i_wdata,
  output wire [31:0]      o_rdata
);

  for (genvar gl = 0; gl < 4; gl++) begin : g_lane
    logic [7:0] r_mem [DEPTH_WORDS];

    always_ff @(posedge clk) begin
      if (i_be[gl]) begin
        r_mem[i_idx] <= i_wdata[8*gl +: 8];
      end
    end

    assign o_rdata[8*gl +: 8] = r_mem[i_idx];
  end

endmodule
`default_nettype wire

// File: rtl/dmem_responder.sv
`default_nettype none
// +----------------------------------------------------------------+
// | Module   : dmem_responder                                      |
// | Brief    : Wait-stated data-memory slave; DMEM_ACCESS_CHECK_EN |
// |            enables alignment and range faults                  |
// | Revision : 1.0                                                 |
// +----------------------------------------------------------------+
module dmem_responder
  import dmem_pkg::*;
#(
  parameter logic [31:0] BASE_ADDR   = c_base_addr_default,
  parameter int          DEPTH_WORDS = 1024,
  parameter int          WAIT_CYCLES = 1
) (
  input wire    clk,
  input wire    rst_n,
  dmem_if.slave bus
);

  localparam int         c_aw   = $clog2(DEPTH_WORDS);
  localparam logic [3:0] c_wait = 4'(WAIT_CYCLES);

  state_t          r_state, w_state_next;
  logic [3:0]      r_cnt, w_cnt_next;
  logic            r_we, r_ext;
  logic [1:0]      r_width;
  logic [31:0]     r_addr, r_wdata, r_rdata;
  logic            w_accept, w_fault;
  logic [31:0]     w_offset;
  logic [c_aw-1:0] w_idx;
  logic [1:0]      w_lane;
  logic [3:0]      w_be;
  logic [31:0]     w_wdata_rep, w_word, w_shifted, w_load, w_resp_rdata;

  assign w_accept = bus.req && (r_state == IDLE);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state <= IDLE;
      r_cnt   <= 4'd0;
    end else begin
      r_state <= w_state_next;
      r_cnt   <= w_cnt_next;
    end
  end

  always_comb begin
    w_state_next = r_state;
    w_cnt_next   = r_cnt;
    case (r_state)
      IDLE: begin
        if (w_accept) begin
          if (c_wait == 4'd0) begin
            w_state_next = RESP;
          end else begin
            w_state_next = WAIT;
            w_cnt_next   = c_wait;
          end
        end
      end
      WAIT: begin
        w_cnt_next = r_cnt - 4'd1;
        if (r_cnt <= 4'd1) w_state_next = RESP;
      end
      RESP:    w_state_next = IDLE;
      default: w_state_next = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_we    <= 1'b0;
      r_ext   <= 1'b0;
      r_width <= W_BYTE;
      r_addr  <= 32'd0;
      r_wdata <= 32'd0;
      r_rdata <= 32'd0;
    end else begin
      if (w_accept) begin
        r_we    <= bus.we;
        r_ext   <= bus.ext;
        r_width <= bus.width;
        r_addr  <= bus.addr;
        r_wdata <= bus.wdata;
      end
      if (r_state == RESP) r_rdata <= w_resp_rdata;
    end
  end

  // Index wraps naturally by keeping only the low offset bits.
  assign w_offset = r_addr - BASE_ADDR;
  assign w_idx    = w_offset[c_aw+1:2];

`ifdef DMEM_ACCESS_CHECK_EN
  localparam logic [31:0] c_span = 32'(4 * DEPTH_WORDS);
  logic w_misalign;
  logic w_unused_offset;
  assign w_misalign = ((r_width == W_HALF) && r_addr[0]) ||
                      ((r_width == W_WORD) && (r_addr[1:0] != 2'b00));
  assign w_fault    = (r_width == W_RSVD) || w_misalign || (w_offset >= c_span);
  assign w_unused_offset = ^w_offset[1:0];
`else
  logic w_unused_offset;
  assign w_fault = (r_width == W_RSVD);
  assign w_unused_offset = ^{w_offset[31:c_aw+2], w_offset[1:0]};
`endif

  always_comb begin
    w_lane = r_addr[1:0];
    if (r_width == W_HALF) w_lane = {r_addr[1], 1'b0};
    if (r_width == W_WORD) w_lane = 2'b00;
  end

  always_comb begin
    w_be        = 4'b0000;
    w_wdata_rep = r_wdata;
    case (r_width)
      W_BYTE: begin
        w_be        = 4'b0001 << w_lane;
        w_wdata_rep = {4{r_wdata[7:0]}};
      end
      W_HALF: begin
        w_be        = 4'b0011 << w_lane;
        w_wdata_rep = {2{r_wdata[15:0]}};
      end
      W_WORD:  w_be = 4'b1111;
      default: w_be = 4'b0000;
    endcase
    // Commit only on the response edge so a reset in WAIT leaves memory intact.
    if ((r_state != RESP) || !r_we || w_fault) w_be = 4'b0000;
  end

  dmem_array #(
    .DEPTH_WORDS (DEPTH_WORDS)
  ) u_array (
    .clk     (clk),
    .i_be    (w_be),
    .i_idx   (w_idx),
    .i_wdata (w_wdata_rep),
    .o_rdata (w_word)
  );

  assign w_shifted = w_word >> {w_lane, 3'b000};

  always_comb begin
    w_load = 32'd0;
    case (r_width)
      W_BYTE:  w_load = {{24{~r_ext & w_shifted[7]}}, w_shifted[7:0]};
      W_HALF:  w_load = {{16{~r_ext & w_shifted[15]}}, w_shifted[15:0]};
      W_WORD:  w_load = w_word;
      default: w_load = 32'd0;
    endcase
  end

  assign w_resp_rdata = (r_we || w_fault) ? 32'd0 : w_load;

  assign bus.ready = (r_state == IDLE);
  assign bus.valid = (r_state == RESP);
  assign bus.err   = (r_state == RESP) && w_fault;
  assign bus.rdata = (r_state == RESP) ? w_resp_rdata : r_rdata;

endmodule
`default_nettype wire

// File: tb/tb_dmem_responder.sv
`default_nettype none
// +----------------------------------------------------------------+
// | Module   : tb_dmem_responder                                   |
// | Brief    : Randomized bench against a byte-level memory model  |
// | Revision : 1.0                                                 |
// +----------------------------------------------------------------+
module tb_dmem_responder;
  import dmem_pkg::*;

  localparam logic [31:0] c_base  = 32'h1001_0000;
  localparam int          c_depth = 64;
  localparam int          c_wait  = 2;

  logic clk    = 1'b0;
  logic rst_n  = 1'b0;
  logic rst0_n = 1'b0;
  int   n_checks = 0;
  int   n_pass   = 0;

  // Byte-addressed reference memories, one per DUT instance.
  logic [7:0] m_bytes [2][c_depth*4];

  dmem_if bus ();
  dmem_if bus0 ();

  dmem_responder #(
    .BASE_ADDR   (c_base),
    .DEPTH_WORDS (c_depth),
    .WAIT_CYCLES (c_wait)
  ) u_dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus)
  );

  dmem_responder #(
    .BASE_ADDR   (c_base),
    .DEPTH_WORDS (c_depth),
    .WAIT_CYCLES (0)
  ) u_dut0 (
    .clk   (clk),
    .rst_n (rst0_n),
    .bus   (bus0)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    if (obs === exp) n_pass++;
    else $display("FAIL %s: observed %h, expected %h", tag, obs, exp);
  endtask

  task automatic model_access(input int inst, input logic we, input logic [31:0] addr,
                              input logic [1:0] width, input logic ext, input logic [31:0] wdata,
                              output logic err, output logic [31:0] rdata);
    int n;
    int b;
    logic [31:0] off;
    logic [31:0] v;
    off   = addr - c_base;
    n     = (width == 2'd0) ? 1 : (width == 2'd1) ? 2 : 4;
    err   = (width == 2'd3);
    rdata = 32'd0;
`ifdef DMEM_ACCESS_CHECK_EN
    if ((addr % n) != 0) err = 1'b1;
    if (off >= 32'(c_depth * 4)) err = 1'b1;
`endif
    if (err) return;
    b = int'((off / 4) % c_depth) * 4 + int'(((addr % 4) / n) * n);
    if (we) begin
      for (int i = 0; i < n; i++) m_bytes[inst][b+i] = wdata[8*i +: 8];
    end else begin
      v = 32'd0;
      for (int i = 0; i < n; i++) v[8*i +: 8] = m_bytes[inst][b+i];
      if (n < 4 && !ext && v[8*n-1])
        for (int i = n; i < 4; i++) v[8*i +: 8] = 8'hFF;
      rdata = v;
    end
  endtask

  task automatic do_txn(input string tag, input logic we, input logic [31:0] addr,
                        input logic [1:0] width, input logic ext, input logic [31:0] wdata,
                        output logic [31:0] got_rdata, output logic got_err);
    logic        e_err;
    logic [31:0] e_rdata;
    int          lat;
    bit          seen;
    @(negedge clk);
    bus.req = 1'b1; bus.we = we; bus.addr = addr;
    bus.width = width; bus.ext = ext; bus.wdata = wdata;
    chk({tag, " ready"}, 32'(bus.ready), 32'd1);
    @(posedge clk);
    #1;
    model_access(0, we, addr, width, ext, wdata, e_err, e_rdata);
    lat  = 0;
    seen = 0;
    while (!seen && lat < 40) begin
      bus.req = 1'($urandom_range(0, 1)); bus.we = 1'($urandom_range(0, 1));
      bus.addr = $urandom(); bus.width = 2'($urandom_range(0, 3));
      bus.ext = 1'($urandom_range(0, 1)); bus.wdata = $urandom();
      @(negedge clk);
      lat++;
      if (bus.valid) seen = 1;
    end
    bus.req = 1'b0;
    chk({tag, " latency"}, 32'(lat), 32'(c_wait + 1));
    got_rdata = bus.rdata;
    got_err   = bus.err;
    chk({tag, " err"}, 32'(got_err), 32'(e_err));
    chk({tag, " rdata"}, got_rdata, e_rdata);
    chk({tag, " ready in resp"}, 32'(bus.ready), 32'd0);
    @(negedge clk);
    chk({tag, " valid strobe"}, 32'(bus.valid), 32'd0);
    chk({tag, " rdata hold"}, bus.rdata, e_rdata);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: observed timeout, expected completion");
    $fatal(1, "watchdog");
  end

  initial begin
    logic [31:0] g;
    logic        e;
    logic        me;
    logic [31:0] mr;
    logic [31:0] off;
    logic [31:0] exp_q[$];
    int          acc;
    int          nval;

    bus.req = 1'b0;  bus.we = 1'b0;  bus.addr = '0;  bus.width = '0;  bus.ext = 1'b0;  bus.wdata = '0;
    bus0.req = 1'b0; bus0.we = 1'b0; bus0.addr = '0; bus0.width = '0; bus0.ext = 1'b0; bus0.wdata = '0;

    #3;
    chk("reset ready", 32'(bus.ready), 32'd1);
    chk("reset valid", 32'(bus.valid), 32'd0);
    chk("reset err", 32'(bus.err), 32'd0);
    chk("reset rdata", bus.rdata, 32'd0);
    chk("reset0 valid", 32'(bus0.valid), 32'd0);
    repeat (2) @(negedge clk);
    rst_n  = 1'b1;
    rst0_n = 1'b1;

    for (int i = 0; i < c_depth; i++)
      do_txn("init", 1'b1, c_base + 32'(4 * i), W_WORD, 1'b0, $urandom(), g, e);

    do_txn("r040 st", 1'b1, c_base + 32'h4, W_WORD, 1'b0, 32'hDEADBEEF, g, e);
    chk("r040 st rdata zero", g, 32'd0);
    do_txn("r040 ld", 1'b0, c_base + 32'h4, W_WORD, 1'b0, 32'd0, g, e);
    chk("r040 data", g, 32'hDEADBEEF);
    do_txn("r041 st", 1'b1, c_base + 32'h5, W_BYTE, 1'b0, 32'h0000_0080, g, e);
    do_txn("r041 lbs", 1'b0, c_base + 32'h5, W_BYTE, 1'b0, 32'd0, g, e);
    chk("r041 sext", g, 32'hFFFFFF80);
    do_txn("r041 lbu", 1'b0, c_base + 32'h5, W_BYTE, 1'b1, 32'd0, g, e);
    chk("r041 zext", g, 32'h00000080);
    do_txn("r041 lw", 1'b0, c_base + 32'h4, W_WORD, 1'b1, 32'd0, g, e);
    chk("r041 word", g, 32'hDEAD80EF);
    do_txn("r042 lh", 1'b0, c_base + 32'h6, W_HALF, 1'b0, 32'd0, g, e);
    chk("r042 half", g, 32'hFFFFDEAD);
    do_txn("r043 misalign", 1'b0, c_base + 32'h2, W_WORD, 1'b0, 32'd0, g, e);
    do_txn("r043 rsvd", 1'b0, c_base + 32'h8, W_RSVD, 1'b0, 32'd0, g, e);
    chk("r043 rsvd err", 32'(e), 32'd1);
    do_txn("rsvd st", 1'b1, c_base + 32'h8, W_RSVD, 1'b0, 32'h5555_5555, g, e);

    // Reset lands in WAIT of a store: no strobe, no write.
    @(negedge clk);
    bus.req = 1'b1; bus.we = 1'b1; bus.addr = c_base + 32'h8;
    bus.width = W_WORD; bus.ext = 1'b0; bus.wdata = 32'h1234_5678;
    @(posedge clk);
    #1;
    bus.req = 1'b0;
    @(negedge clk);
    chk("r044 wait valid", 32'(bus.valid), 32'd0);
    rst_n = 1'b0;
    #1;
    chk("r044 rst ready", 32'(bus.ready), 32'd1);
    chk("r044 rst rdata", bus.rdata, 32'd0);
    chk("r044 rst err", 32'(bus.err), 32'd0);
    repeat (3) begin
      @(negedge clk);
      chk("r044 valid in reset", 32'(bus.valid), 32'd0);
    end
    rst_n = 1'b1;
    @(negedge clk);
    chk("r044 ready after", 32'(bus.ready), 32'd1);
    chk("r044 valid after", 32'(bus.valid), 32'd0);
    do_txn("r044 ld", 1'b0, c_base + 32'h8, W_WORD, 1'b0, 32'd0, g, e);

    for (int i = 0; i < 200; i++) begin
      off = 32'($urandom_range(0, c_depth * 4 - 1));
      if ($urandom_range(0, 7) == 0) off = off + 32'(c_depth * 4 * $urandom_range(1, 3));
      if ($urandom_range(0, 15) == 0) off = off - 32'(c_depth * 4);
      do_txn("rand", 1'($urandom_range(0, 1)), c_base + off, 2'($urandom_range(0, 3)),
             1'($urandom_range(0, 1)), $urandom(), g, e);
    end

    // Back-to-back with zero wait states and req held high throughout.
    acc  = 0;
    nval = 0;
    for (int k = 0; k < 32; k++) begin
      @(negedge clk);
      if (bus0.valid) begin
        nval++;
        chk("tput ready in valid", 32'(bus0.ready), 32'd0);
        if (exp_q.size() > 0) chk("tput rdata", bus0.rdata, exp_q.pop_front());
        else chk("tput spurious valid", 32'd1, 32'd0);
      end
      if (bus0.ready) begin
        bus0.req   = 1'b1;
        bus0.we    = (acc < 8);
        bus0.addr  = c_base + 32'(4 * (acc % 8));
        bus0.width = W_WORD;
        bus0.ext   = 1'b0;
        bus0.wdata = $urandom();
        model_access(1, bus0.we, bus0.addr, bus0.width, bus0.ext, bus0.wdata, me, mr);
        exp_q.push_back(mr);
        acc++;
      end
    end
    bus0.req = 1'b0;
    chk("tput accepts", 32'(acc), 32'd16);
    chk("tput valids", 32'(nval), 32'd16);

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
`default_nettype wire
